// File: rtl/scr1_ahb_sram_resp_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : scr1_ahb_sram_resp_if
// Description : AHB-Lite bus bundle between the dmem interconnect (master
//               side) and the SRAM responder (slave side).
// Revision    : 1.0 - initial release
// ============================================================================
interface scr1_ahb_sram_resp_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface
`default_nettype wire

// File: rtl/scr1_ahb_sram_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : scr1_ahb_sram_resp
// Description : AHB-Lite responder onto a single-port synchronous SRAM.
//               Zero-wait reads and writes via a one-entry posted write
//               buffer with byte-merged read forwarding; two-cycle ERROR
//               response for illegal sizes and misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module scr1_ahb_sram_resp #(
    parameter int MEM_AW = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scr1_ahb_sram_resp_if.slave  ahb,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [3:0]           mem_be,
    output logic [MEM_AW-1:0]    mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    typedef enum logic [1:0] {
        ERR_IDLE = 2'd0,
        ERR_1    = 2'd1,
        ERR_2    = 2'd2
    } err_state_e;

    err_state_e err_q, err_d;

    // Data-phase register: the transfer whose data phase is in progress
    logic              dp_valid_q, dp_valid_d;
    logic              dp_write_q, dp_write_d;
    logic [2:0]        dp_size_q,  dp_size_d;
    logic [MEM_AW+1:0] dp_addr_q,  dp_addr_d;
    logic [3:0]        dp_be_q,    dp_be_d;

    // Posted write buffer
    logic              wbuf_valid_q, wbuf_valid_d;
    logic [MEM_AW-1:0] wbuf_addr_q,  wbuf_addr_d;
    logic [3:0]        wbuf_be_q,    wbuf_be_d;
    logic [31:0]       wbuf_data_q,  wbuf_data_d;

    logic       acc, legal, stall, ready_int;
    logic       go_ok, go_err, rd_acc, capture, drain, fwd_hit;
    logic [3:0] be_new;

    // Bits of the bus the responder intentionally ignores
    logic unused_bits;
    assign unused_bits = ^{ahb.haddr[31:MEM_AW+2], ahb.htrans[0], dp_size_q, dp_addr_q[1:0]};

    // Address-phase decode, legality, stall and port arbitration
    always_comb begin
        acc    = ahb.hsel & ahb.htrans[1] & ahb.hready;
        legal  = 1'b0;
        be_new = 4'b0000;
        case (ahb.hsize)
            3'd0: begin legal = 1'b1;                       be_new = 4'b0001 << ahb.haddr[1:0]; end
            3'd1: begin legal = ~ahb.haddr[0];              be_new = ahb.haddr[1] ? 4'b1100 : 4'b0011; end
            3'd2: begin legal = (ahb.haddr[1:0] == 2'b00);  be_new = 4'b1111; end
            default: ;
        endcase
        // A read arriving behind a write while the buffer is still occupied
        // must wait one cycle so the buffer can drain before the new capture.
        stall     = wbuf_valid_q & dp_valid_q & dp_write_q & ahb.hsel & ahb.htrans[1] & ~ahb.hwrite;
        ready_int = ~stall & (err_q != ERR_1);
        go_ok     = acc & ready_int & legal;
        go_err    = acc & ready_int & ~legal;
        rd_acc    = go_ok & ~ahb.hwrite;
        capture   = dp_valid_q & dp_write_q & ready_int;
        drain     = wbuf_valid_q & ~rd_acc;
        fwd_hit   = wbuf_valid_q & (wbuf_addr_q == dp_addr_q[MEM_AW+1:2]);
    end

    // Datapath next state and bus/SRAM outputs
    always_comb begin
        dp_valid_d   = dp_valid_q;
        dp_write_d   = dp_write_q;
        dp_size_d    = dp_size_q;
        dp_addr_d    = dp_addr_q;
        dp_be_d      = dp_be_q;
        wbuf_valid_d = capture | (wbuf_valid_q & ~drain);
        wbuf_addr_d  = wbuf_addr_q;
        wbuf_be_d    = wbuf_be_q;
        wbuf_data_d  = wbuf_data_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_be       = 4'b0000;
        mem_addr     = '0;
        mem_wdata    = 32'h0;
        ahb.hrdata   = 32'h0;
        ahb.hreadyout = ready_int;
        ahb.hresp    = (err_q != ERR_IDLE);

        if (ready_int) begin
            dp_valid_d = go_ok;
            if (go_ok) begin
                dp_write_d = ahb.hwrite;
                dp_size_d  = ahb.hsize;
                dp_addr_d  = ahb.haddr[MEM_AW+1:0];
                dp_be_d    = be_new;
            end
        end

        if (capture) begin
            wbuf_addr_d = dp_addr_q[MEM_AW+1:2];
            wbuf_be_d   = dp_be_q;
            wbuf_data_d = ahb.hwdata;
        end

        if (rd_acc) begin
            mem_req  = 1'b1;
            mem_addr = ahb.haddr[MEM_AW+1:2];
        end else if (drain) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_be    = wbuf_be_q;
            mem_addr  = wbuf_addr_q;
            mem_wdata = wbuf_data_q;
        end

        // Bytes still sitting in the buffer are newer than the SRAM copy
        if (dp_valid_q & ~dp_write_q) begin
            for (int i = 0; i < 4; i++) begin
                ahb.hrdata[8*i +: 8] = (fwd_hit & wbuf_be_q[i]) ? wbuf_data_q[8*i +: 8]
                                                                 : mem_rdata[8*i +: 8];
            end
        end
    end

    // Error response sequencing: two cycles of ERROR per illegal transfer
    always_comb begin
        err_d = err_q;
        case (err_q)
            ERR_IDLE: if (go_err) err_d = ERR_1;
            ERR_1:    err_d = ERR_2;
            ERR_2:    err_d = go_err ? ERR_1 : ERR_IDLE;
            default:  err_d = ERR_IDLE;
        endcase
    end

    // Error state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= ERR_IDLE;
        end else begin
            err_q <= err_d;
        end
    end

    // Data-phase and write-buffer registers; reset discards any posted write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid_q   <= 1'b0;
            dp_write_q   <= 1'b0;
            dp_size_q    <= 3'd0;
            dp_addr_q    <= '0;
            dp_be_q      <= 4'b0000;
            wbuf_valid_q <= 1'b0;
            wbuf_addr_q  <= '0;
            wbuf_be_q    <= 4'b0000;
            wbuf_data_q  <= 32'h0;
        end else begin
            dp_valid_q   <= dp_valid_d;
            dp_write_q   <= dp_write_d;
            dp_size_q    <= dp_size_d;
            dp_addr_q    <= dp_addr_d;
            dp_be_q      <= dp_be_d;
            wbuf_valid_q <= wbuf_valid_d;
            wbuf_addr_q  <= wbuf_addr_d;
            wbuf_be_q    <= wbuf_be_d;
            wbuf_data_q  <= wbuf_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scr1_ahb_sram_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_scr1_ahb_sram_resp
// Description : Self-checking bench for the AHB SRAM responder with an SRAM
//               model, a reference memory and a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scr1_ahb_sram_resp;
    localparam int MEM_AW = 10;
    localparam int WORDS  = 1 << MEM_AW;
    localparam int LIMIT  = 200;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic              mem_req, mem_we;
    logic [3:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    scr1_ahb_sram_resp_if bus();
    assign bus.hready = bus.hreadyout;

    scr1_ahb_sram_resp #(.MEM_AW(MEM_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ahb       (bus),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // SRAM model with bench-controlled init/preload port
    logic [31:0]       sram    [WORDS];
    logic [31:0]       ref_mem [WORDS];
    int                sram_writes = 0;
    logic              init_req = 1'b0;
    logic              pl_en = 1'b0;
    logic [MEM_AW-1:0] pl_addr = '0;
    logic [31:0]       pl_data = 32'h0;

    function automatic logic [31:0] init_word(input int i);
        return (32'h9E3779B9 * (i + 1)) ^ i;
    endfunction

    always @(posedge clk) begin
        if (init_req) for (int i = 0; i < WORDS; i++) sram[i] <= init_word(i);
        if (pl_en) sram[pl_addr] <= pl_data;
        if (mem_req && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            sram_writes <= sram_writes + 1;
        end else if (mem_req) begin
            mem_rdata <= sram[mem_addr];
        end
    end

    // Scoreboard and per-cycle log of the last sequence
    logic [31:0]       exp_q[$];
    logic [31:0]       obs_q[$];
    xfer_t             seq[$];
    logic              log_req [256];
    logic              log_we  [256];
    logic [3:0]        log_be  [256];
    logic [MEM_AW-1:0] log_addr[256];
    logic [31:0]       log_wdata[256];
    logic              log_hro [256];
    int                waits, resps, ncyc;

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [2:0] size, input logic [31:0] addr, input logic [31:0] data);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.data = data;
        return x;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    return 4'b0001 << a;
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic drive_idle();
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0;
        bus.hsize = 3'd0; bus.haddr = 32'h0; bus.hwdata = 32'h0;
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        pl_addr = w[MEM_AW-1:0]; pl_data = d; pl_en = 1'b1;
        ref_mem[w] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Pipelined AHB master: runs seq, then 'extra' idle cycles
    task automatic run_seq(input int extra);
        int    idx = 0;
        int    cyc = 0;
        int    left = extra;
        logic  dp_v = 1'b0;
        xfer_t cur, dp;
        logic [3:0] be;
        int    w;
        waits = 0; resps = 0;
        dp = mk(0, 0, 0, 0, 0, 0);
        while (cyc < LIMIT) begin
            if (idx >= seq.size() && !dp_v) begin
                if (left == 0) break;
                left--;
            end
            cur = (idx < seq.size()) ? seq[idx] : mk(0, 2'b00, 0, 0, 0, 0);
            bus.hsel = cur.sel; bus.htrans = cur.trans; bus.hwrite = cur.wr;
            bus.hsize = cur.size; bus.haddr = cur.addr;
            bus.hwdata = (dp_v && dp.wr) ? dp.data : 32'h0;
            @(negedge clk);
            log_req[cyc] = mem_req; log_we[cyc] = mem_we; log_be[cyc] = mem_be;
            log_addr[cyc] = mem_addr; log_wdata[cyc] = mem_wdata; log_hro[cyc] = bus.hreadyout;
            if (!bus.hreadyout) waits++;
            if (bus.hresp) resps++;
            if (dp_v && !dp.wr && bus.hreadyout) obs_q.push_back(bus.hrdata);
            if (bus.hreadyout) begin
                dp_v = 1'b0;
                if (idx < seq.size()) begin
                    if (cur.sel && cur.trans[1]) begin
                        dp = cur; dp_v = 1'b1;
                        w = int'(cur.addr[MEM_AW+1:2]);
                        if (cur.wr) begin
                            be = exp_be(cur.size, cur.addr[1:0]);
                            for (int b = 0; b < 4; b++)
                                if (be[b]) ref_mem[w][8*b +: 8] = cur.data[8*b +: 8];
                        end else begin
                            exp_q.push_back(ref_mem[w]);
                        end
                    end
                    idx++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        ncyc = cyc;
        if (cyc >= LIMIT) begin
            errors++; checks++;
            $display("FAIL seq_timeout: ran %0d cycles, required fewer than %0d", cyc, LIMIT);
        end
        seq.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.hreadyout, bus.hresp, bus.hrdata, mem_req, mem_we, mem_be} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got hro=%b hresp=%b hrdata=%h req=%b we=%b be=%h, required 1 0 0 0 0 0",
                     bus.hreadyout, bus.hresp, bus.hrdata, mem_req, mem_we, mem_be);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus.hreadyout, bus.hresp, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset_idle: got %b required 100", {bus.hreadyout, bus.hresp, mem_req});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] e, o;
        seq.push_back(mk(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF));
        run_seq(3);
        checks++;
        if (log_req[1] !== 1'b0) begin
            errors++; $display("FAIL write_no_early_access: got req=%b required 0", log_req[1]);
        end
        checks++;
        if ({log_req[2], log_we[2], log_addr[2], log_be[2], log_wdata[2]} !== {1'b1, 1'b1, 10'd4, 4'hF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL write_drain_t2: got req=%b we=%b addr=%0d be=%h wdata=%h required 1 1 4 f deadbeef",
                     log_req[2], log_we[2], log_addr[2], log_be[2], log_wdata[2]);
        end
        seq.push_back(mk(1, 2'b10, 0, 3'd2, 32'h10, 32'h0));
        run_seq(1);
        checks++;
        if (waits !== 0) begin errors++; $display("FAIL read_waits: got %0d required 0", waits); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
            checks++;
            if (o !== e || o !== 32'hDEADBEEF) begin errors++; $display("FAIL read_back: got %h required %h", o, e); end
        end
    endtask

    task automatic test_forward();
        logic [31:0] e, o;
        preload(4, 32'h11223344);
        seq.push_back(mk(1, 2'b10, 1, 3'd0, 32'h13, 32'hAA000000));
        seq.push_back(mk(1, 2'b10, 0, 3'd2, 32'h10, 32'h0));
        run_seq(3);
        checks++;
        if (waits !== 0) begin errors++; $display("FAIL forward_waits: got %0d required 0", waits); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
            checks++;
            if (o !== e || o !== 32'hAA223344) begin errors++; $display("FAIL forward_data: got %h required %h", o, e); end
        end
        checks++;
        if (sram[4] !== 32'hAA223344) begin errors++; $display("FAIL forward_sram: got %h required aa223344", sram[4]); end
    endtask

    task automatic test_wait_state();
        logic [31:0] e, o;
        seq.push_back(mk(1, 2'b10, 1, 3'd2, 32'h0, 32'hA5A50001));
        seq.push_back(mk(1, 2'b10, 1, 3'd2, 32'h4, 32'h5A5A0002));
        seq.push_back(mk(1, 2'b10, 0, 3'd2, 32'h8, 32'h0));
        run_seq(3);
        checks++;
        if (waits !== 1 || log_hro[2] !== 1'b0) begin
            errors++; $display("FAIL stall_waits: got waits=%0d hro@2=%b required 1 and 0", waits, log_hro[2]);
        end
        checks++;
        if ({log_we[2], log_addr[2]} !== {1'b1, 10'd0}) begin
            errors++; $display("FAIL stall_drain: got we=%b addr=%0d required 1 0", log_we[2], log_addr[2]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL stall_read: got %h required %h", o, e); end
        end
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (sram[w] !== ref_mem[w]) begin errors++; $display("FAIL stall_sram[%0d]: got %h required %h", w, sram[w], ref_mem[w]); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            seq.push_back(mk(1, 2'b10, 1, 3'd2, 32'h40 + 4*i, 32'h1000 * (i + 1) + 32'h77));
        seq.push_back(mk(1, 2'b10, 1, 3'd1, 32'h4E, 32'hBEEF0000));
        run_seq(3);
        checks++;
        if (waits !== 0) begin errors++; $display("FAIL b2b_waits: got %0d required 0", waits); end
        for (int w = 16; w < 20; w++) begin
            checks++;
            if (sram[w] !== ref_mem[w]) begin errors++; $display("FAIL b2b_sram[%0d]: got %h required %h", w, sram[w], ref_mem[w]); end
        end
    endtask

    task automatic test_read_stream();
        logic [31:0] e, o;
        int nwe;
        seq.push_back(mk(1, 2'b10, 1, 3'd2, 32'h30, 32'hCAFEF00D));
        seq.push_back(mk(1, 2'b10, 0, 3'd2, 32'h30, 32'h0));
        seq.push_back(mk(1, 2'b11, 0, 3'd2, 32'h34, 32'h0));
        seq.push_back(mk(1, 2'b10, 0, 3'd0, 32'h31, 32'h0));
        seq.push_back(mk(1, 2'b10, 0, 3'd1, 32'h32, 32'h0));
        run_seq(3);
        nwe = 0;
        for (int c = 1; c < 5; c++) if (log_req[c] && log_we[c]) nwe++;
        checks++;
        if (nwe !== 0 || log_we[5] !== 1'b1 || waits !== 0) begin
            errors++; $display("FAIL stream_starve: got writes_during=%0d we@5=%b waits=%0d required 0 1 0", nwe, log_we[5], waits);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL stream_read: got %h required %h", o, e); end
        end
        checks++;
        if (sram[12] !== 32'hCAFEF00D) begin errors++; $display("FAIL stream_sram: got %h required cafef00d", sram[12]); end
    endtask

    task automatic test_error(input logic [2:0] size, input logic [31:0] addr);
        logic [31:0] e;
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b0; bus.hsize = size; bus.haddr = addr; bus.hwdata = 32'h0;
        @(negedge clk);
        checks++;
        if ({bus.hreadyout, bus.hresp, mem_req} !== 3'b100) begin
            errors++; $display("FAIL err_addr_phase sz=%0d: got %b required 100", size, {bus.hreadyout, bus.hresp, mem_req});
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({bus.hreadyout, bus.hresp, mem_req} !== 3'b010) begin
            errors++; $display("FAIL err_cycle1 sz=%0d: got %b required 010", size, {bus.hreadyout, bus.hresp, mem_req});
        end
        @(posedge clk); #1;
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hsize = 3'd2; bus.haddr = 32'h20;
        @(negedge clk);
        checks++;
        if ({bus.hreadyout, bus.hresp, mem_req, mem_we} !== 4'b1110) begin
            errors++; $display("FAIL err_cycle2 sz=%0d: got %b required 1110", size, {bus.hreadyout, bus.hresp, mem_req, mem_we});
        end
        e = ref_mem[8];
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({bus.hreadyout, bus.hresp} !== 2'b10 || bus.hrdata !== e) begin
            errors++; $display("FAIL err_followup_read sz=%0d: got hro/hresp=%b hrdata=%h required 10 %h",
                               size, {bus.hreadyout, bus.hresp}, bus.hrdata, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_idle_busy();
        int nreq;
        seq.push_back(mk(1, 2'b01, 0, 3'd2, 32'h10, 32'h0));
        seq.push_back(mk(1, 2'b00, 1, 3'd2, 32'h10, 32'h0));
        seq.push_back(mk(0, 2'b10, 0, 3'd2, 32'h10, 32'h0));
        seq.push_back(mk(0, 2'b11, 1, 3'd2, 32'h0, 32'h12345678));
        run_seq(2);
        nreq = 0;
        for (int c = 0; c < ncyc; c++) if (log_req[c]) nreq++;
        checks++;
        if (nreq !== 0 || waits !== 0 || resps !== 0 || exp_q.size() !== 0) begin
            errors++; $display("FAIL idle_busy: got req=%0d waits=%0d err=%0d reads=%0d required all 0", nreq, waits, resps, exp_q.size());
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] saved;
        int wcount;
        saved = ref_mem[8];
        seq.push_back(mk(1, 2'b10, 1, 3'd2, 32'h20, 32'h0BADF00D));
        run_seq(0);
        wcount = sram_writes;
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({bus.hreadyout, bus.hresp, bus.hrdata, mem_req, mem_we, mem_be} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0}) begin
            errors++; $display("FAIL midop_reset_outputs: got hro=%b hresp=%b hrdata=%h req=%b we=%b be=%h required 1 0 0 0 0 0",
                               bus.hreadyout, bus.hresp, bus.hrdata, mem_req, mem_we, mem_be);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        checks++;
        if (sram_writes !== wcount || sram[8] !== saved) begin
            errors++; $display("FAIL midop_discard: got writes=%0d word=%h required %0d %h", sram_writes, sram[8], wcount, saved);
        end
        ref_mem[8] = saved;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive_idle();
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_forward();
        test_wait_state();
        test_back_to_back();
        test_read_stream();
        test_error(3'd1, 32'h1);
        test_error(3'd3, 32'h0);
        test_error(3'd2, 32'h2);
        test_idle_busy();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scr1_ahb_sram_resp.md
# scr1_ahb_sram_resp

AHB-Lite responder that bridges single (non-burst-optimised) AHB transfers from the data-side interconnect onto a single-port synchronous SRAM. It is the slave end of the dmem AHB path. It gives zero-wait-state reads and writes using a one-entry posted write buffer with byte-merged read forwarding. It returns the two-cycle AHB ERROR response for illegal sizes and misaligned accesses.

## Interface
- MEM_AW, 10: SRAM word-address width; capacity is 4·2^MEM_AW bytes, and HADDR[MEM_AW+1:2] indexes the SRAM.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- hsel  in  1  slave select from the decoder.
- haddr  in  32  address-phase address.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1 means write.
- hsize  in  3  0=byte, 1=halfword, 2=word; values above 2 are illegal.
- hwdata  in  32  write data, lane-positioned, valid in the data phase.
- hready  in  1  bus HREADY, which qualifies address-phase acceptance.
- hreadyout  out  1  this slave's ready.
- hresp  out  1  0=OKAY, 1=ERROR.
- hrdata  out  32  read data.
- mem_req  out  1  SRAM access this cycle.
- mem_we  out  1  1 means write.
- mem_be  out  4  byte enables for a write.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid the cycle after a read mem_req.

## Operation
- Accepted transfer (acc) means: hsel & htrans[1] & hready. IDLE and BUSY transfers get a zero-wait OKAY and cause no SRAM access.
- Legality check at acc:
  - error if hsize>2;
  - error if hsize=1 and haddr[0]=1;
  - error if hsize=2 and haddr[1:0]≠0.
- A legal acc registers hwrite, hsize, haddr[MEM_AW+1:0] and the byte-enables into the data-phase register.
- Byte-enable generation:
  - byte: 1<<haddr[1:0];
  - half: 0011 or 1100 selected by haddr[1];
  - word: 1111.
- Read: mem_req=1, mem_we=0, mem_addr=haddr word, all combinational in the acc cycle. In the data phase, hrdata = mem_rdata, except that bytes enabled in the write buffer are replaced by the buffer bytes when the buffer is valid and its word address equals the read word.
- Write: at the end of an OKAY write data phase (hreadyout=1), the data-phase address, be and hwdata are captured into the write buffer (wbuf) and wbuf_valid is set.
- Drain: in any cycle where wbuf_valid=1 and no read acc occurs:
  - drive mem_req=1, mem_we=1, mem_addr/mem_be/mem_wdata from wbuf;
  - wbuf_valid clears, unless a new write is captured in the same cycle.
- Port priority: read acc, then drain.
- Stall: stall = wbuf_valid & write data phase & hsel & htrans[1] & ~hwrite. It is independent of hready, so there is no loop.
  - In a stall cycle hreadyout=0, the read is not accepted and the drain executes.
  - The next cycle completes the write with OKAY and captures it.
- Error FSM, states IDLE → ERR1 → ERR2 → IDLE:
  - an illegal acc moves IDLE → ERR1;
  - ERR1: hreadyout=0, hresp=1;
  - ERR2: hreadyout=1, hresp=1; a new acc in ERR2 is evaluated normally;
  - errored transfers never touch the SRAM or wbuf.
- hrdata is 0 outside an OKAY read data phase.
- Outside the cases above, hreadyout=1 and hresp=0.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, mem_req=0, mem_we=0, mem_be=0, wbuf_valid=0, error FSM=IDLE, data-phase register invalid.
- Reset mid-operation: a pending wbuf write is discarded and the SRAM is not written.
- Read latency: address phase at cycle t, hrdata valid at t+1 with zero wait states.
- Write: address phase at t, data phase at t+1, capture at the end of t+1. The SRAM is written at the earliest cycle ≥ t+2 with no read acc.
- Back-to-back writes: a drain and a capture in the same cycle give zero waits.
- A write data phase concurrent with a read address phase while wbuf is valid adds exactly one wait state.
- A write data phase concurrent with a read address phase while wbuf is empty needs no wait: the capture happens and the drain is deferred.
- An error response always takes exactly 2 cycles.
- An indefinite read stream starves the drain; forwarding keeps all reads coherent.

## Test plan
- Reset, then word write 0xDEADBEEF to 0x10, then idle → mem_req/mem_we at t+2 with mem_addr=4 and be=1111; a read of 0x10 returns 0xDEADBEEF with no waits.
- Byte write 0xAA to 0x13, immediately followed by a word read of 0x10, with the SRAM holding 0x11223344 → hrdata=0xAA223344 (forwarded), hreadyout never 0.
- Writes W1 to 0x0 and W2 to 0x4, then read R of 0x8, back-to-back → exactly one wait state in W2's data phase; the SRAM ends with both words written and R returns correct data.
- Halfword access at 0x1 → hreadyout 0 then 1, with hresp=1 for both cycles; no mem_req. Repeat the same check with hsize=3.
- BUSY/IDLE transfers and hsel=0 → OKAY with no waits, and mem_req=0 apart from drains.
- Assert rst_n while wbuf holds a write → the SRAM is never written and all outputs take their reset values.
